// File: rtl/serial_byte_receiver_pkg.sv
// rtl/serial_byte_receiver_pkg.sv - shared serial line encodings and defaults
//
// Shared by the receiver and future transmit blocks: the 3-bit receive
// state encodings, the default bit period and the counter width helper.

package serial_byte_receiver_pkg;

    // Clock cycles per serial bit period when the instantiating block does
    // not override it.
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } rx_state_t;

    // Width of a counter that can hold 0..clks_per_bit-1 with one bit of
    // headroom (11 bits at the largest legal period of 1024).
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit) + 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for one asynchronous input
//
// Ports:
//   i_clk   - sampling clock
//   i_reset - synchronous active-high reset; both flops reset to 1
//   i_async - asynchronous input (serial line, idle high)
//   o_sync  - synchronized copy of i_async, two cycles of latency

module bit_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Reset to 1 so a line held idle never looks like a start bit while
    // the flops fill after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/serial_byte_receiver.sv
// rtl/serial_byte_receiver.sv - 8N1 serial byte receiver with valid/ready output
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - synchronous active-high reset
//   rx          - asynchronous serial line, idle high
//   byte_out    - last received byte, LSB is the first data bit
//   byte_valid  - byte_out holds an unconsumed byte
//   byte_ready  - consumer takes byte_out on this edge when byte_valid is set
//   frame_error - one-cycle pulse when a stop bit is sampled low
//   overrun     - one-cycle pulse when a completed byte is dropped because
//                 the holding register is still full

module serial_byte_receiver
    import serial_byte_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CW = cnt_width(CLKS_PER_BIT);

    // Counter terminal values: the half period lands the first sample in
    // the middle of the start bit, every later sample is one full period on.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;

    rx_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_rx_s;
    logic          w_tick_half;
    logic          w_tick_bit;
    logic          w_byte_done;
    logic          w_stop_bad;
    logic          w_load;
    logic          w_drop;

    bit_sync u_bit_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_tick_half = (r_cnt == HALF_LAST);
    assign w_tick_bit  = (r_cnt == BIT_LAST);

    // Next-state logic. The counter free-runs inside START/DATA/STOP and is
    // cleared at every sample point, so each sample is exactly one period
    // after the previous one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_done = 1'b0;
        w_stop_bad  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (w_tick_half) begin
                    w_cnt_nxt = '0;
                    // A line back high at mid start bit was a glitch.
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_tick_bit) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (w_tick_bit) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_shift_nxt = '0;
                        w_state_nxt = ST_RECOVER;
                    end
                end
            end

            ST_RECOVER: begin
                // A low stop bit usually means a break or a wrong baud rate;
                // wait for the line to go idle before hunting for a start bit.
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A completed byte goes into the holding register if it is empty or is
    // being taken on this same edge; otherwise the new byte is dropped and
    // the held one is kept intact.
    assign w_load = w_byte_done && (!r_valid || byte_ready);
    assign w_drop = w_byte_done && r_valid && !byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_ferr  <= w_stop_bad;
            r_ovr   <= w_drop;
            if (w_load) begin
                r_byte  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && byte_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign byte_out    = r_byte;
    assign byte_valid  = r_valid;
    assign frame_error = r_ferr;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb/tb_serial_byte_receiver.sv - scoreboard bench for serial_byte_receiver

module tb_serial_byte_receiver;

    localparam int P_A = 4;
    localparam int P_B = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       ready_a = 1'b0;
    logic       ready_b = 1'b0;
    logic [7:0] out_a, out_b;
    logic       valid_a, valid_b, ferr_a, ferr_b, ovr_a, ovr_b;

    serial_byte_receiver #(.CLKS_PER_BIT(P_A)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .byte_out(out_a),
        .byte_valid(valid_a), .byte_ready(ready_a),
        .frame_error(ferr_a), .overrun(ovr_a)
    );

    serial_byte_receiver #(.CLKS_PER_BIT(P_B)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .byte_out(out_b),
        .byte_valid(valid_b), .byte_ready(ready_b),
        .frame_error(ferr_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    int vcyc_a = 0, fcnt_a = 0, ocnt_a = 0, rise_a = 0;
    int vcyc_b = 0, fcnt_b = 0, ocnt_b = 0, rise_b = 0;
    logic pv_a = 1'b0, pf_a = 1'b0, po_a = 1'b0;
    logic pv_b = 1'b0, pf_b = 1'b0, po_b = 1'b0;
    int last_fall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor A: pops the scoreboard on every transfer, tracks pulses.
    always @(negedge clk) begin
        if (valid_a === 1'b1) vcyc_a++;
        if (valid_a === 1'b1 && pv_a !== 1'b1) rise_a = cyc;
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_byte: got %0h expected none", out_a);
            end else begin
                chk("a_byte", {24'd0, out_a}, {24'd0, q_a.pop_front()});
            end
        end
        if (ferr_a === 1'b1) begin
            fcnt_a++;
            chk("a_ferr_width", {31'd0, pf_a}, 32'd0);
        end
        if (ovr_a === 1'b1) begin
            ocnt_a++;
            chk("a_ovr_width", {31'd0, po_a}, 32'd0);
        end
        pv_a = valid_a; pf_a = ferr_a; po_a = ovr_a;
    end

    always @(negedge clk) begin
        if (valid_b === 1'b1) vcyc_b++;
        if (valid_b === 1'b1 && pv_b !== 1'b1) rise_b = cyc;
        if (valid_b === 1'b1 && ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_byte: got %0h expected none", out_b);
            end else begin
                chk("b_byte", {24'd0, out_b}, {24'd0, q_b.pop_front()});
            end
        end
        if (ferr_b === 1'b1) begin
            fcnt_b++;
            chk("b_ferr_width", {31'd0, pf_b}, 32'd0);
        end
        if (ovr_b === 1'b1) begin
            ocnt_b++;
            chk("b_ovr_width", {31'd0, po_b}, 32'd0);
        end
        pv_b = valid_b; pf_b = ferr_b; po_b = ovr_b;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic hold_rx(input int which, input logic b, input int n);
        if (which == 0) rx_a = b; else rx_b = b;
        idle(n);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic stop_bit);
        int p;
        p = (which == 0) ? P_A : P_B;
        last_fall = cyc;
        hold_rx(which, 1'b0, p);
        for (int i = 0; i < 8; i++) hold_rx(which, d[i], p);
        hold_rx(which, stop_bit, p);
    endtask

    int vc, fe, ov;

    task automatic snap();
        vc = vcyc_a; fe = fcnt_a; ov = ocnt_a;
    endtask

    initial begin
        reset = 1'b1;
        idle(4);
        chk("rst_a_byte", {24'd0, out_a}, 32'h00);
        chk("rst_a_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_a_ferr", {31'd0, ferr_a}, 32'd0);
        chk("rst_a_ovr", {31'd0, ovr_a}, 32'd0);
        chk("rst_b_byte", {24'd0, out_b}, 32'h00);
        chk("rst_b_valid", {31'd0, valid_b}, 32'd0);
        reset = 1'b0;
        idle(4);

        // 0xA5 with consumer always ready; valid one cycle, 41 cycles after rx falls.
        ready_a = 1'b1;
        snap();
        q_a.push_back(8'hA5);
        send_frame(0, 8'hA5, 1'b1);
        idle(6);
        chk("a5_latency", rise_a - last_fall, 32'd41);
        chk("a5_valid_cycles", vcyc_a - vc, 32'd1);
        chk("a5_ferr", fcnt_a - fe, 32'd0);
        chk("a5_ovr", ocnt_a - ov, 32'd0);
        chk("a5_drained", q_a.size(), 32'd0);

        // One-cycle glitch is rejected.
        snap();
        hold_rx(0, 1'b0, 1);
        hold_rx(0, 1'b1, 30);
        chk("glitch_valid", vcyc_a - vc, 32'd0);
        chk("glitch_ferr", fcnt_a - fe, 32'd0);

        // 0x3C with a low stop bit, line held low, then released.
        snap();
        send_frame(0, 8'h3C, 1'b0);
        hold_rx(0, 1'b0, 20);
        chk("ferr_pulse", fcnt_a - fe, 32'd1);
        hold_rx(0, 1'b1, 40);
        chk("ferr_no_restart_ferr", fcnt_a - fe, 32'd1);
        chk("ferr_no_byte", vcyc_a - vc, 32'd0);
        q_a.push_back(8'h5A);
        send_frame(0, 8'h5A, 1'b1);
        idle(6);
        chk("after_ferr_5a_drained", q_a.size(), 32'd0);
        chk("after_ferr_5a_valid", vcyc_a - vc, 32'd1);

        // Overrun: 0x11 then 0x22 with nobody consuming.
        ready_a = 1'b0;
        snap();
        q_a.push_back(8'h11);
        send_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1);
        idle(4);
        chk("ovr_pulse", ocnt_a - ov, 32'd1);
        chk("ovr_held_byte", {24'd0, out_a}, 32'h11);
        chk("ovr_held_valid", {31'd0, valid_a}, 32'd1);
        ready_a = 1'b1;
        idle(1);
        ready_a = 1'b0;
        idle(1);
        chk("ovr_drain_valid", {31'd0, valid_a}, 32'd0);
        chk("ovr_drained", q_a.size(), 32'd0);

        // Ready raised exactly on the edge where 0x22 completes.
        snap();
        q_a.push_back(8'h11);
        q_a.push_back(8'h22);
        send_frame(0, 8'h11, 1'b1);
        idle(2);
        fork
            send_frame(0, 8'h22, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        idle(3);
        chk("same_edge_byte", {24'd0, out_a}, 32'h22);
        chk("same_edge_valid", {31'd0, valid_a}, 32'd1);
        chk("same_edge_ovr", ocnt_a - ov, 32'd0);
        ready_a = 1'b1;
        idle(1);
        ready_a = 1'b0;
        idle(1);
        chk("same_edge_drained", q_a.size(), 32'd0);
        chk("same_edge_valid_clr", {31'd0, valid_a}, 32'd0);

        // Reset during data bit 4 of 0xFF, then 0x5A.
        ready_a = 1'b1;
        snap();
        hold_rx(0, 1'b0, P_A);
        hold_rx(0, 1'b1, 4 * P_A + 2);
        reset = 1'b1;
        idle(2);
        chk("midrst_byte", {24'd0, out_a}, 32'h00);
        chk("midrst_valid", {31'd0, valid_a}, 32'd0);
        chk("midrst_ferr", {31'd0, ferr_a}, 32'd0);
        chk("midrst_ovr", {31'd0, ovr_a}, 32'd0);
        reset = 1'b0;
        hold_rx(0, 1'b1, 40);
        chk("midrst_no_valid", vcyc_a - vc, 32'd0);
        chk("midrst_no_ferr", fcnt_a - fe, 32'd0);
        chk("midrst_no_ovr", ocnt_a - ov, 32'd0);
        q_a.push_back(8'h5A);
        send_frame(0, 8'h5A, 1'b1);
        idle(6);
        chk("midrst_5a_drained", q_a.size(), 32'd0);
        chk("midrst_5a_valid", vcyc_a - vc, 32'd1);

        // 0xA5 at 16 clocks per bit: valid 3 + 8 + 144 = 155 cycles after rx falls.
        ready_b = 1'b1;
        q_b.push_back(8'hA5);
        send_frame(1, 8'hA5, 1'b1);
        idle(10);
        chk("b_a5_latency", rise_b - last_fall, 32'd155);
        chk("b_a5_valid_cycles", vcyc_b, 32'd1);
        chk("b_a5_drained", q_b.size(), 32'd0);
        chk("b_a5_ferr", fcnt_b, 32'd0);
        chk("b_a5_ovr", ocnt_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
SERIAL_BYTE_RECEIVER -- requirements
Module: serial_byte_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit period; legal range 4..1024.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port byte_out  output  8  last received byte, LSB = first data bit; feeds the byte-to-bits splitter.
REQ-006 SHALL have port byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-007 SHALL have port byte_ready  input  1  consumer accepts byte_out this cycle.
REQ-008 SHALL have port frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because holding register full.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, RECOVER with a bit-period counter and a 3-bit data-bit index.
REQ-012 IDLE: rx_s==0 in cycle t0 -> START, counter cleared.
REQ-013 START: at t0+H, H=CLKS_PER_BIT/2 (integer division), sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: data bit i (i=0..7) sampled at t0+H+(i+1)*CLKS_PER_BIT, shifted into the shift register LSB first; after bit 7 -> STOP.
REQ-015 STOP: sample at t0+H+9*CLKS_PER_BIT; 1 -> byte complete, next state IDLE; 0 -> frame_error=1 next cycle, shift register discarded, next state RECOVER.
REQ-016 RECOVER: stay until rx_s==1, then IDLE; no new frame starts while in RECOVER.
REQ-017 On byte complete, byte_out/byte_valid SHALL update on the following clock edge (byte_valid rises at cycle t0+H+9*CLKS_PER_BIT+1).
REQ-018 Handshake: transfer occurs on an edge where byte_valid && byte_ready; byte_valid then clears unless a new byte loads on the same edge.
REQ-019 byte_out SHALL remain stable while byte_valid=1 and no transfer occurs.
REQ-020 Byte complete with byte_valid=1 and byte_ready=0: old byte kept, new byte discarded, overrun=1 for one cycle.
REQ-021 Byte complete with byte_valid=1 and byte_ready=1 on the same edge: old byte transferred, new byte loaded, byte_valid stays 1, no overrun.
REQ-022 byte_ready while byte_valid=0 SHALL have no effect.
REQ-023 frame_error and overrun SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-024 On reset: state IDLE, counter 0, index 0, shift register 0x00, byte_out 0x00, byte_valid 0, frame_error 0, overrun 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes from IDLE on the next falling edge after reset deasserts.
REQ-026 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-027 State encodings (3-bit) and default CLKS_PER_BIT SHALL live in a shared serial package/include used by this and future transmit blocks.
REQ-028 Synchronizer SHALL be a separate sub-module named bit_sync (2 flops, reset value 1).
REQ-029 Counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; no other arithmetic wider than 11 bits.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), byte_ready=1 -> byte_out=0xA5, byte_valid high exactly one cycle, no error pulses.
REQ-031 rx low for 1 cycle then high -> no byte_valid, no frame_error, state back in IDLE.
REQ-032 Frame 0x3C with stop bit 0, rx held low 20 more cycles -> one frame_error pulse, byte_valid stays 0, no new frame until rx high then next falling edge.
REQ-033 Frames 0x11 then 0x22 back-to-back, byte_ready=0 -> byte_out=0x11 held, one overrun pulse at second completion; then byte_ready=1 -> 0x11 transferred, byte_valid=0.
REQ-034 byte_valid=1 (0x11), byte_ready raised exactly on 0x22 completion edge -> byte_out=0x22, byte_valid=1, overrun=0.
REQ-035 reset asserted during DATA bit 4 of frame 0xFF -> all outputs at reset values, no pulse; subsequent frame 0x5A received correctly; repeat REQ-030 with CLKS_PER_BIT=16.
